motor_pos_ctrl: RTL and testbench

Closed-loop position controller that sequences the motor PWM/encoder peripheral. On every sample tick it reads the encoder position count from the motor's Avalon slave, computes a saturated PI correction against a software setpoint, and writes the signed duty command back. It sits between the Nios-side Avalon bus, which programs its CSRs, and the motor peripheral, which it drives as the sole Avalon master.

---
 rtl/motor_pos_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_motor_pos_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pos_ctrl.sv
// Sampled PI position controller acting as sole Avalon master of the motor PWM/encoder slave.
// Define MOTOR_POS_CTRL_INTEGRAL_EN for full PI; otherwise the integral path is removed (P-only).
module motor_pos_ctrl #(
    parameter int unsigned CTR_LEN     = 11,
    parameter int unsigned TICK_CYCLES = 50000
) (
    input  logic        clk_clk,
    input  logic        rst_reset_n,
    input  logic [1:0]  csr_address,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    output logic        m_address,
    output logic        m_write,
    output logic        m_read,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned U_W   = CTR_LEN + 1;
    localparam int unsigned SUM_W = 42;
    localparam logic signed [SUM_W-1:0] DUTY_HI = SUM_W'((1 << CTR_LEN) - 1);
    localparam logic signed [SUM_W-1:0] DUTY_LO = -DUTY_HI;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_ERR, S_MUL, S_ACC, S_SUM, S_WRITE, S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    read_d, write_d, sat_d;
    logic [31:0]             wdata_d;
    logic [31:0]             setpoint_q, pos_q;
    logic [15:0]             kp_q;
    logic                    enable_q, enable_prev_q, overrun_q, saturated_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [15:0]      err_q, err_sat_c;
    logic signed [32:0]      p_q, diff_c;
    logic signed [SUM_W-1:0] shift_c;
    logic signed [U_W-1:0]   u_c;
    logic                    sat_c, tick_c, ctrl_wr_c, clr_overrun_c;

    assign m_address     = 1'b0;
    assign ctrl_wr_c     = csr_write && (csr_address == 2'd3);
    assign clr_overrun_c = ctrl_wr_c && csr_writedata[2];
    assign tick_c        = enable_q && (cnt_q == CNT_W'(TICK_CYCLES - 1));

    // Sample tick counter, held at zero while disabled
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n)  cnt_q <= '0;
        else if (!enable_q || tick_c) cnt_q <= '0;
        else               cnt_q <= cnt_q + CNT_W'(1);
    end

    // CSR registers
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            setpoint_q    <= '0;
            kp_q          <= '0;
            enable_q      <= 1'b0;
            enable_prev_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            enable_prev_q <= enable_q;
            if (csr_write && csr_address == 2'd0) setpoint_q <= csr_writedata;
            if (csr_write && csr_address == 2'd1) kp_q <= csr_writedata[15:0];
            if (ctrl_wr_c) enable_q <= csr_writedata[0];
            if (tick_c && state_q != S_IDLE) overrun_q <= 1'b1;
            else if (clr_overrun_c)          overrun_q <= 1'b0;
        end
    end

    // Error saturated to a symmetric 16-bit range
    always_comb begin
        diff_c = {setpoint_q[31], setpoint_q} - {pos_q[31], pos_q};
        if (diff_c > 33'sd32767)       err_sat_c = 16'sh7FFF;
        else if (diff_c < -33'sd32767) err_sat_c = 16'sh8001;
        else                           err_sat_c = diff_c[15:0];
    end

`ifdef MOTOR_POS_CTRL_INTEGRAL_EN
    logic [15:0]        ki_q;
    logic signed [23:0] integ_q, integ_next_c;
    logic signed [24:0] integ_sum_c;
    logic signed [40:0] i_q;
    logic               clr_integ_c;

    assign clr_integ_c = ctrl_wr_c && csr_writedata[1];

    // Clamped integrator; an explicit clear beats accumulation
    always_comb begin
        integ_sum_c = 25'(integ_q) + 25'(err_q);
        if (clr_integ_c)                      integ_next_c = '0;
        else if (integ_sum_c > 25'sd8388607)  integ_next_c = 24'sd8388607;
        else if (integ_sum_c < -25'sd8388607) integ_next_c = -24'sd8388607;
        else                                  integ_next_c = integ_sum_c[23:0];
    end

    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            ki_q    <= '0;
            integ_q <= '0;
            i_q     <= '0;
        end else begin
            if (csr_write && csr_address == 2'd2) ki_q <= csr_writedata[15:0];
            if (clr_integ_c || state_q == S_STOP) integ_q <= '0;
            else if (state_q == S_ACC)            integ_q <= integ_next_c;
            if (state_q == S_ACC) i_q <= 41'($signed({1'b0, ki_q})) * 41'(integ_next_c);
        end
    end

    assign shift_c = (SUM_W'(p_q) + SUM_W'(i_q)) >>> 8;
`else
    assign shift_c = SUM_W'(p_q) >>> 8;
`endif

    // Command clamp; the most negative code is never emitted
    always_comb begin
        sat_c = 1'b1;
        if (shift_c > DUTY_HI)      u_c = DUTY_HI[U_W-1:0];
        else if (shift_c < DUTY_LO) u_c = DUTY_LO[U_W-1:0];
        else begin
            u_c   = shift_c[U_W-1:0];
            sat_c = 1'b0;
        end
    end

    // Datapath pipeline registers
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            pos_q       <= '0;
            err_q       <= '0;
            p_q         <= '0;
            saturated_q <= 1'b0;
        end else begin
            if (state_q == S_READ && !m_waitrequest) pos_q <= m_readdata;
            if (state_q == S_ERR) err_q <= err_sat_c;
            if (state_q == S_MUL) p_q <= 33'($signed({1'b0, kp_q})) * 33'(err_q);
            saturated_q <= sat_d;
        end
    end

    // State and registered master outputs
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            state_q     <= S_IDLE;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_writedata <= '0;
        end else begin
            state_q     <= state_d;
            m_read      <= read_d;
            m_write     <= write_d;
            m_writedata <= wdata_d;
        end
    end

    // Next state; bus transfers always finish before a disable is honoured
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable_prev_q && !enable_q) state_d = S_STOP;
                     else if (tick_c)                state_d = S_READ;
            S_READ:  if (!m_waitrequest) state_d = enable_q ? S_ERR : S_STOP;
            S_ERR:   state_d = enable_q ? S_MUL : S_STOP;
`ifdef MOTOR_POS_CTRL_INTEGRAL_EN
            S_MUL:   state_d = enable_q ? S_ACC : S_STOP;
`else
            S_MUL:   state_d = enable_q ? S_SUM : S_STOP;
`endif
            S_ACC:   state_d = enable_q ? S_SUM : S_STOP;
            S_SUM:   state_d = enable_q ? S_WRITE : S_STOP;
            S_WRITE: if (!m_waitrequest) state_d = enable_q ? S_IDLE : S_STOP;
            S_STOP:  if (!m_waitrequest) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        read_d  = (state_d == S_READ);
        write_d = (state_d == S_WRITE) || (state_d == S_STOP);
        wdata_d = m_writedata;
        sat_d   = saturated_q;
        if (state_q == S_SUM && state_d == S_WRITE) begin
            wdata_d = {{(32 - U_W){u_c[U_W-1]}}, u_c};
            sat_d   = sat_c;
        end else if (state_d == S_STOP && state_q != S_STOP) begin
            wdata_d = '0;
        end
    end

    // Zero-wait CSR read mux
    always_comb begin
        csr_readdata = '0;
        if (csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata = setpoint_q;
                2'd1:    csr_readdata = {16'h0, kp_q};
`ifdef MOTOR_POS_CTRL_INTEGRAL_EN
                2'd2:    csr_readdata = {16'h0, ki_q};
`endif
                2'd3:    csr_readdata = {28'h0, saturated_q, overrun_q,
                                         (state_q != S_IDLE), enable_q};
                default: csr_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_pos_ctrl.sv
// Directed bench for motor_pos_ctrl with a short sample period and a simple motor-slave model.
module tb_motor_pos_ctrl;

`ifdef MOTOR_POS_CTRL_INTEGRAL_EN
    localparam int LAT   = 5;
    localparam int GAP   = 3;
    localparam bit INTEG = 1'b1;
`else
    localparam int LAT   = 4;
    localparam int GAP   = 0;
    localparam bit INTEG = 1'b0;
`endif

    logic        clk_clk = 1'b0;
    logic        rst_reset_n = 1'b0;
    logic [1:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic        m_address, m_write, m_read;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;

    motor_pos_ctrl #(.CTR_LEN(11), .TICK_CYCLES(8)) dut (
        .clk_clk(clk_clk), .rst_reset_n(rst_reset_n),
        .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_read(csr_read), .csr_readdata(csr_readdata),
        .m_address(m_address), .m_write(m_write), .m_read(m_read), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    int          n_chk = 0, n_err = 0;
    int          cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_edge = 0, wr_edge = 0, ctrl_edge = 0;
    logic [31:0] last_cmd = '0, prev_wdata = '0;
    logic        overlap = 1'b0, unstable = 1'b0, prev_rd_stall = 1'b0, prev_wr_stall = 1'b0;

    // Motor-slave monitor: transfer log and bus protocol watch
    always @(posedge clk_clk) begin
        cyc <= cyc + 1;
        if (m_read && !m_waitrequest) begin
            rd_cnt  <= rd_cnt + 1;
            rd_edge <= cyc;
        end
        if (m_write && !m_waitrequest) begin
            wr_cnt   <= wr_cnt + 1;
            wr_edge  <= cyc;
            last_cmd <= m_writedata;
        end
        if (csr_write && csr_address == 2'd3) ctrl_edge <= cyc;
        if (m_read && m_write) overlap <= 1'b1;
        if (rst_reset_n) begin
            if (prev_rd_stall && !m_read) unstable <= 1'b1;
            if (prev_wr_stall && (!m_write || m_writedata !== prev_wdata)) unstable <= 1'b1;
        end
        prev_rd_stall <= m_read && m_waitrequest;
        prev_wr_stall <= m_write && m_waitrequest;
        prev_wdata    <= m_writedata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk_clk); #1;
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk_clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        #1 d = csr_readdata;
        csr_read = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_wr(input int target, input string tag);
        int n = 0;
        while (wr_cnt < target && n < 200) begin
            @(negedge clk_clk);
            n++;
        end
        chk({tag, "_wait"}, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        @(negedge clk_clk);
        while (!m_read && n < 200) begin
            @(negedge clk_clk);
            n++;
        end
        chk({tag, "_wait"}, 32'(m_read), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          base, rd0, wr0;

        // Reset values
        repeat (3) @(negedge clk_clk);
        chk("rst_m_read", 32'(m_read), 32'd0);
        chk("rst_m_write", 32'(m_write), 32'd0);
        chk("rst_m_wdata", m_writedata, 32'd0);
        chk("rst_m_addr", 32'(m_address), 32'd0);
        csr_chk("rst_setpoint", 2'd0, 32'd0);
        csr_chk("rst_status", 2'd3, 32'd0);
        rst_reset_n = 1'b1;

        // First command and latency
        csr_wr(2'd0, 32'd100);
        csr_wr(2'd1, 32'h0100);
        csr_wr(2'd3, 32'h1);
        wait_wr(1, "first");
        chk("first_cmd", last_cmd, 32'd100);
        chk("enable_to_read", 32'(rd_edge - ctrl_edge), 32'd9);
        chk("read_to_write", 32'(wr_edge - rd_edge), 32'(LAT));
        csr_chk("status_unsat", 2'd3, 32'h1);

        // Saturation both ways
        csr_wr(2'd0, 32'd100000);
        base = wr_cnt;
        wait_wr(base + 2, "sat_pos");
        chk("sat_pos_cmd", last_cmd, 32'd2047);
        csr_chk("sat_pos_status", 2'd3, 32'h9);
        csr_wr(2'd0, 32'(-100000));
        base = wr_cnt;
        wait_wr(base + 2, "sat_neg");
        chk("sat_neg_cmd", last_cmd, 32'hFFFF_F801);
        csr_chk("sat_neg_status", 2'd3, 32'h9);

        // Disable from running, then integral-only accumulation
        csr_wr(2'd3, 32'h0);
        repeat (12) @(negedge clk_clk);
        chk("disable_stop_cmd", last_cmd, 32'd0);
        csr_rd(2'd3, d);
        chk("disable_status", d & 32'h3, 32'h0);
        csr_wr(2'd0, 32'd1000);
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd2, 32'h10);
        csr_chk("ki_readback", 2'd2, INTEG ? 32'h10 : 32'h0);
        base = wr_cnt;
        csr_wr(2'd3, 32'h1);
        wait_wr(base + 1, "pi1");
        chk("pi_cmd1", last_cmd, INTEG ? 32'd62 : 32'd0);
        wait_wr(base + 2, "pi2");
        chk("pi_cmd2", last_cmd, INTEG ? 32'd125 : 32'd0);
        wait_wr(base + 3, "pi3");
        chk("pi_cmd3", last_cmd, INTEG ? 32'd187 : 32'd0);

        // Stalled read, disabled mid-transfer
        m_waitrequest = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        wait_rd("stall_read");
        csr_wr(2'd3, 32'h0);
        repeat (3) begin
            @(negedge clk_clk);
            chk("read_held", 32'(m_read), 32'd1);
        end
        m_waitrequest = 1'b0;
        wait_wr(wr0 + 1, "stop");
        chk("stop_cmd", last_cmd, 32'd0);
        chk("stop_one_read", 32'(rd_cnt), 32'(rd0 + 1));
        chk("read_to_stop", 32'(wr_edge - rd_edge), 32'd1);
        base = wr_cnt;
        csr_wr(2'd3, 32'h1);
        wait_wr(base + 1, "reenable");
        chk("reenable_cmd", last_cmd, INTEG ? 32'd62 : 32'd0);

        // Long read stall causes an overrun
        csr_wr(2'd0, 32'd100);
        csr_wr(2'd1, 32'h0100);
        csr_wr(2'd2, 32'h0);
        base = wr_cnt;
        wait_wr(base + 2, "settle");
        m_waitrequest = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        wait_rd("ovr_read");
        repeat (10) @(negedge clk_clk);
        m_waitrequest = 1'b0;
        wait_wr(wr0 + 1, "ovr");
        chk("ovr_one_read", 32'(rd_cnt), 32'(rd0 + 1));
        chk("ovr_cmd", last_cmd, 32'd100);
        csr_chk("ovr_status", 2'd3, 32'h5);
        repeat (GAP) @(negedge clk_clk);
        chk("ovr_no_extra_read", 32'(rd_cnt), 32'(rd0 + 1));
        csr_wr(2'd3, 32'h5);
        @(negedge clk_clk);
        csr_rd(2'd3, d);
        chk("ovr_cleared", d & 32'h5, 32'h1);

        // Asynchronous reset during a write
        begin
            int n = 0;
            @(negedge clk_clk);
            while (!m_write && n < 100) begin
                @(negedge clk_clk);
                n++;
            end
        end
        chk("saw_write", 32'(m_write), 32'd1);
        m_waitrequest = 1'b1;
        #1 rst_reset_n = 1'b0;
        #1;
        chk("arst_m_write", 32'(m_write), 32'd0);
        chk("arst_m_read", 32'(m_read), 32'd0);
        chk("arst_m_wdata", m_writedata, 32'd0);
        @(negedge clk_clk);
        csr_chk("arst_setpoint", 2'd0, 32'd0);
        csr_chk("arst_kp", 2'd1, 32'd0);
        csr_chk("arst_status", 2'd3, 32'd0);
        @(negedge clk_clk);
        rst_reset_n = 1'b1;
        m_waitrequest = 1'b0;
        repeat (2) @(negedge clk_clk);

        chk("no_rd_wr_overlap", 32'(overlap), 32'd0);
        chk("stall_stable", 32'(unstable), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
